// File: rtl/fir_capture_if.sv
// rtl/fir_capture_if.sv - sample ingest and block readout stream bundle for fir_capture
interface fir_capture_if #(
   parameter int DATA_W = 33
) ();
   logic [DATA_W-1:0] din;
   logic              din_valid;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              rd_ready;
   logic              rd_last;

   modport master (
      input  din, din_valid, rd_ready,
      output rd_data, rd_valid, rd_last
   );

   modport slave (
      output din, din_valid, rd_ready,
      input  rd_data, rd_valid, rd_last
   );
endinterface

// File: rtl/fir_capture.sv
// rtl/fir_capture.sv - records a block of FIR output samples (immediate or signed-threshold
// start) into RAM and streams it back out through a valid/ready port
module fir_capture #(
   parameter int DATA_W = 33,
   parameter int ADDR_W = 10
) (
   input  logic              sclk,
   input  logic              s_rst,
   input  logic              arm,
   input  logic              trig_mode,
   input  logic [DATA_W-1:0] trig_level,
   input  logic [ADDR_W-1:0] cap_len,
   output logic              busy,
   output logic              done,
   fir_capture_if.master     io
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W:0] CNT_DEPTH = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, READOUT} state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] trig_level_q, trig_level_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d;
   logic [ADDR_W:0]   rd_cnt_q, rd_cnt_d;
   logic              s1_vld_q, s1_vld_d;
   logic              s1_last_q, s1_last_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic              rd_last_q, rd_last_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] ram_rd_q;
   logic              we, ram_re;
   logic [ADDR_W-1:0] waddr, raddr;
   logic              trig_hit, wr_last, out_adv, s1_load, rd_pend, fin;

   always_comb begin
      trig_hit = io.din_valid && ($signed(io.din) >= $signed(trig_level_q));
      wr_last  = (wr_cnt_q + CNT_ONE) == len_q;
      out_adv  = !rd_valid_q || io.rd_ready;
      s1_load  = !s1_vld_q || out_adv;
      rd_pend  = rd_cnt_q < len_q;
      fin      = rd_valid_q && io.rd_ready && rd_last_q;
      waddr    = wr_cnt_q[ADDR_W-1:0];
      raddr    = rd_cnt_q[ADDR_W-1:0];

      state_d      = state_q;
      trig_level_d = trig_level_q;
      len_d        = len_q;
      wr_cnt_d     = wr_cnt_q;
      rd_cnt_d     = rd_cnt_q;
      s1_vld_d     = s1_vld_q;
      s1_last_d    = s1_last_q;
      rd_data_d    = rd_data_q;
      rd_valid_d   = rd_valid_q;
      rd_last_d    = rd_last_q;
      done_d       = 1'b0;
      we           = 1'b0;
      ram_re       = 1'b0;

      case (state_q)
         IDLE: begin
            if (arm) begin
               trig_level_d = trig_level;
               len_d        = (cap_len == '0) ? CNT_DEPTH : {1'b0, cap_len};
               wr_cnt_d     = '0;
               rd_cnt_d     = '0;
               s1_vld_d     = 1'b0;
               s1_last_d    = 1'b0;
               state_d      = trig_mode ? WAIT_TRIG : CAPTURE;
            end
         end
         // wr_cnt_q is still 0 here, so the trigger sample lands at address 0
         WAIT_TRIG, CAPTURE: begin
            if ((state_q == WAIT_TRIG) ? trig_hit : io.din_valid) begin
               we       = 1'b1;
               wr_cnt_d = wr_cnt_q + CNT_ONE;
               state_d  = wr_last ? READOUT : CAPTURE;
            end
         end
         READOUT: begin
            if (out_adv) begin
               rd_valid_d = s1_vld_q;
               rd_last_d  = s1_vld_q && s1_last_q;
               if (s1_vld_q) rd_data_d = ram_rd_q;
            end
            // stage 1 is the RAM read register; it only reloads when its word moves on
            if (s1_load) begin
               s1_vld_d  = rd_pend;
               s1_last_d = rd_pend && ((rd_cnt_q + CNT_ONE) == len_q);
               if (rd_pend) begin
                  ram_re   = 1'b1;
                  rd_cnt_d = rd_cnt_q + CNT_ONE;
               end
            end
            if (fin) begin
               done_d     = 1'b1;
               rd_valid_d = 1'b0;
               rd_last_d  = 1'b0;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge sclk) begin
      if (s_rst) begin
         state_q      <= IDLE;
         trig_level_q <= '0;
         len_q        <= '0;
         wr_cnt_q     <= '0;
         rd_cnt_q     <= '0;
         s1_vld_q     <= 1'b0;
         s1_last_q    <= 1'b0;
         rd_data_q    <= '0;
         rd_valid_q   <= 1'b0;
         rd_last_q    <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         trig_level_q <= trig_level_d;
         len_q        <= len_d;
         wr_cnt_q     <= wr_cnt_d;
         rd_cnt_q     <= rd_cnt_d;
         s1_vld_q     <= s1_vld_d;
         s1_last_q    <= s1_last_d;
         rd_data_q    <= rd_data_d;
         rd_valid_q   <= rd_valid_d;
         rd_last_q    <= rd_last_d;
         done_q       <= done_d;
         busy_q       <= busy_d;
      end
   end

   always_ff @(posedge sclk) begin
      if (we) mem[waddr] <= io.din;
      if (ram_re) ram_rd_q <= mem[raddr];
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign io.rd_data  = rd_data_q;
   assign io.rd_valid = rd_valid_q;
   assign io.rd_last  = rd_last_q;
endmodule

// File: tb/tb_fir_capture.sv
// tb/tb_fir_capture.sv - directed self-checking bench for fir_capture
module tb_fir_capture;
   localparam int DATA_W = 33;
   localparam int ADDR_W = 10;

   logic              sclk = 1'b0;
   logic              s_rst;
   logic              arm;
   logic              trig_mode;
   logic [DATA_W-1:0] trig_level;
   logic [ADDR_W-1:0] cap_len;
   logic              busy;
   logic              done;

   fir_capture_if #(.DATA_W(DATA_W)) bus ();

   fir_capture #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .sclk       (sclk),
      .s_rst      (s_rst),
      .arm        (arm),
      .trig_mode  (trig_mode),
      .trig_level (trig_level),
      .cap_len    (cap_len),
      .busy       (busy),
      .done       (done),
      .io         (bus)
   );

   always #5 sclk = ~sclk;

   int n_assert = 0;
   int n_fail   = 0;
   logic [DATA_W-1:0] exp_q[$];
   logic bp_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge sclk);
      #1;
   endtask

   task automatic push(input int v);
      exp_q.push_back(DATA_W'(v));
   endtask

   task automatic feed(input int v);
      bus.din       = DATA_W'(v);
      bus.din_valid = 1'b1;
      tick();
   endtask

   task automatic do_arm(input logic mode, input int level, input int len);
      arm        = 1'b1;
      trig_mode  = mode;
      trig_level = DATA_W'(level);
      cap_len    = ADDR_W'(len);
      tick();
      arm        = 1'b0;
   endtask

   // pat_sel 0: rd_ready always high; 1: ready follows bp_pat then stays high
   task automatic drain(input int n, input int pat_sel);
      int  k = 0;
      int  cyc = 0;
      int  budget = 4 * n + 20;
      logic r;
      logic stalled = 1'b0;
      while (k < n && cyc < budget) begin
         r = (pat_sel == 0) ? 1'b1 : ((cyc < 7) ? bp_pat[cyc] : 1'b1);
         bus.rd_ready = r;
         if (stalled) check("hold_valid", bus.rd_valid, 1);
         if (pat_sel == 0 && k > 0) check("no_bubble", bus.rd_valid, 1);
         if (bus.rd_valid) begin
            check(r ? "rd_data" : "hold_data", bus.rd_data, exp_q[k]);
            check(r ? "rd_last" : "hold_last", bus.rd_last, (k == n - 1));
            if (r) k++;
            stalled = !r;
         end
         tick();
         cyc++;
      end
      check("handshakes", k, n);
      check("done_pulse", done, 1);
      check("busy_after", busy, 0);
      check("valid_after", bus.rd_valid, 0);
      bus.rd_ready = 1'b0;
      tick();
      check("done_one_cycle", done, 0);
      exp_q.delete();
   endtask

   initial begin
      s_rst = 1'b1; arm = 1'b0; trig_mode = 1'b0; trig_level = '0; cap_len = '0;
      bus.din = '0; bus.din_valid = 1'b0; bus.rd_ready = 1'b0;
      tick();
      tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_valid", bus.rd_valid, 0);
      check("rst_last", bus.rd_last, 0);
      check("rst_data", bus.rd_data, 0);
      s_rst = 1'b0;
      tick();

      // immediate capture; the valid sample alongside arm must be dropped
      bus.din = DATA_W'(999); bus.din_valid = 1'b1;
      do_arm(1'b0, 0, 4);
      check("busy_rise", busy, 1);
      feed(5); feed(-3); feed(100); feed(7);
      bus.din_valid = 1'b0;
      check("lat_e0", bus.rd_valid, 0);
      tick();
      check("lat_e1", bus.rd_valid, 0);
      tick();
      check("lat_e2", bus.rd_valid, 1);
      push(5); push(-3); push(100); push(7);
      drain(4, 0);

      // threshold 50; -20 must not trigger under a signed compare
      do_arm(1'b1, 50, 3);
      feed(-20);
      for (int v = 10; v <= 100; v += 10) feed(v);
      bus.din_valid = 1'b0;
      push(50); push(60); push(70);
      drain(3, 0);

      // all samples below -1 keep it waiting; -1 itself triggers a length-1 block
      do_arm(1'b1, -1, 1);
      feed(-5); feed(-100); feed(-2);
      bus.din_valid = 1'b0;
      tick(); tick();
      check("wait_busy", busy, 1);
      check("wait_valid", bus.rd_valid, 0);
      feed(-1);
      bus.din_valid = 1'b0;
      push(-1);
      drain(1, 0);

      // backpressure, with arm pulses during CAPTURE and READOUT
      do_arm(1'b0, 0, 4);
      feed(11); feed(22);
      arm = 1'b1; trig_mode = 1'b1; cap_len = ADDR_W'(2);
      feed(33);
      arm = 1'b0;
      feed(44);
      bus.din_valid = 1'b0;
      tick(); tick(); tick();
      arm = 1'b1; cap_len = ADDR_W'(1);
      tick();
      arm = 1'b0;
      check("arm_ro_busy", busy, 1);
      push(11); push(22); push(33); push(44);
      drain(4, 1);

      // reset after 2 of 8 samples
      do_arm(1'b0, 0, 8);
      feed(1); feed(2);
      s_rst = 1'b1; bus.din = DATA_W'(3);
      tick();
      check("mid_rst_busy", busy, 0);
      check("mid_rst_valid", bus.rd_valid, 0);
      check("mid_rst_done", done, 0);
      s_rst = 1'b0; bus.din_valid = 1'b0;
      tick();
      check("post_rst_done", done, 0);
      check("post_rst_busy", busy, 0);
      do_arm(1'b0, 0, 2);
      feed(201); feed(202);
      bus.din_valid = 1'b0;
      push(201); push(202);
      drain(2, 0);

      // full depth via cap_len = 0
      do_arm(1'b0, 0, 0);
      for (int i = 0; i < 1024; i++) feed(i);
      bus.din_valid = 1'b0;
      for (int i = 0; i < 1024; i++) push(i);
      drain(1024, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/fir_capture.md
# fir_capture

Capture buffer at the output of the FIR filter: records a block of `fir_out` samples into on-chip RAM, starting either immediately or on a signed-threshold trigger, then streams the block out through a valid/ready port. It is the sink counterpart to the sample source that drives `fir_in`. It gives the team an in-system way to read filter responses for comparison against golden data.

## Interface

- `DATA_W`, 33: sample width, matching `fir_out`.
- `ADDR_W`, 10: buffer address width; DEPTH = 2**ADDR_W = 1024.

- `sclk`  in  1  system clock, all logic on its rising edge.
- `s_rst`  in  1  reset; synchronous, active-high.
- `din`  in  DATA_W  filter output sample, two's complement.
- `din_valid`  in  1  `din` is a new sample this cycle.
- `arm`  in  1  one-cycle pulse; starts a capture. Honoured only in IDLE.
- `trig_mode`  in  1  0 = immediate, 1 = threshold trigger. Sampled with `arm`.
- `trig_level`  in  DATA_W  signed threshold. Sampled with `arm`.
- `cap_len`  in  ADDR_W  number of samples to capture. 0 means DEPTH. Sampled with `arm`.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse on the final readout handshake.
- `rd_data`  out  DATA_W  captured sample.
- `rd_valid`  out  1  `rd_data` is valid.
- `rd_ready`  in  1  consumer accepts `rd_data`.
- `rd_last`  out  1  qualifies the final sample of the block; only meaningful with `rd_valid`.

## Operation

- **States:** IDLE, WAIT_TRIG, CAPTURE, READOUT.
- **IDLE:** on `arm`, latch `trig_mode`, `trig_level` and `cap_len` (0 becomes DEPTH), and clear `wr_ptr`/count.
  - If `trig_mode` = 1, go to WAIT_TRIG.
  - Otherwise go to CAPTURE.
- **WAIT_TRIG:**
  - A cycle with `din_valid` and signed `din >= trig_level` is the trigger.
  - The trigger sample is written at address 0 and counts as sample 1.
  - Next state is CAPTURE, or READOUT directly if the length is 1.
  - Samples below the level are discarded.
- **CAPTURE:**
  - Each `din_valid` writes `mem[wr_ptr] <= din` and increments `wr_ptr`.
  - The write that brings the count to the latched length moves the state to READOUT.
  - In immediate mode, a `din_valid` in the same cycle as `arm` is not captured; the first capture is the first valid cycle after `arm`.
- **READOUT:**
  - Samples are presented in address order 0..len-1.
  - `rd_valid` stays asserted and `rd_data` stays stable until `rd_valid && rd_ready`.
  - `rd_last` is high with the final sample.
  - On the final handshake: `done` pulses, `rd_valid` drops, and the state returns to IDLE on the same edge.
- **Ignored inputs:** `din_valid` is ignored in IDLE and READOUT. `arm` is ignored in every state except IDLE; it does not restart an operation.
- **Pointers:** ADDR_W wide, so a DEPTH-sample capture writes addresses 0..1023 with no overwrite. The write counter is ADDR_W+1 wide.
- **RAM:** one synchronous-read, single-write memory of DEPTH x DATA_W. It is not cleared by reset.
- **Data path:** no arithmetic on data. Samples are stored and returned bit-exact at full width. The comparison is signed, at DATA_W width.

## Timing

- **Reset values:** state IDLE; `busy`, `done`, `rd_valid`, `rd_last` = 0; `rd_data` = 0; pointers = 0.
- **Reset mid-operation:** `s_rst` has priority over everything, in any state.
  - Next cycle the block is in IDLE with the reset values above.
  - Any partial capture is abandoned.
  - `done` is not pulsed.
- **`busy`:** rises the cycle after the `arm` edge. It falls the cycle after the final handshake, in the same cycle `done` is high.
- **Readout latency:** `rd_valid` first rises on the second rising edge after the edge that wrote the last sample. That is one RAM read cycle plus the output register.
- **Throughput:** one sample per cycle with `rd_ready` held high; no bubbles between samples. A read-ahead or skid register is required for this.
- **Backpressure:** `rd_ready` low holds `rd_data`, `rd_valid` and `rd_last` unchanged indefinitely.
- **`done`:** registered; high exactly one cycle, the cycle after the final handshake edge.
- **Ingest rate:** `din_valid` may be high every cycle; no samples are lost in CAPTURE.

## Test plan

- **Immediate capture:**
  - Stimulus: `arm` with mode 0 and `cap_len`=4, then `din` = 5, -3, 100, 7 on consecutive valid cycles, with `rd_ready`=1.
  - Required: `rd_data` = 5, -3, 100, 7 back to back; `rd_last` only on 7; `done` one cycle; `busy` low afterwards.
- **Threshold trigger:**
  - Stimulus: mode 1, `trig_level`=50, `cap_len`=3, ramp `din` = 10, 20, ..., 100.
  - Required: captured block is 50, 60, 70.
  - Negative check: with `trig_level`=-1 and all-negative input below -1, the block stays in WAIT_TRIG and `busy` stays 1.
- **Backpressure:**
  - Stimulus: `cap_len`=4, `rd_ready` toggled 1,0,0,1,0,1,1.
  - Required: each sample is held stable while not accepted; order is preserved; exactly 4 handshakes.
- **Full depth:**
  - Stimulus: `cap_len`=0, immediate mode, 1024-sample counting pattern.
  - Required: 1024 samples out in order; `rd_last` on sample 1023; no wrap corruption.
- **Reset mid-capture:**
  - Stimulus: assert `s_rst` after 2 of 8 samples.
  - Required: next cycle `busy`=0 and `rd_valid`=0, with no `done`. A fresh `arm` with `cap_len`=2 then returns only the new samples.
- **Arm while busy:**
  - Stimulus: pulse `arm` during CAPTURE and again during READOUT.
  - Required: no restart and no length change; the original block completes intact.
